pwm_multi: RTL
==============

# pwm_multi

Multi-channel PWM generator: the parametrised successor to the team's single-channel start/stop PWM. It drives CHANNELS outputs from one shared period counter. Each channel has its own active (on-time) count, and edge-aligned or center-aligned counting is selectable. Period/active updates are double-buffered, so a new setting takes effect only at a period boundary and outputs never glitch. It sits between the register/control logic and the output pins (motor/LED/power-stage drive).

## Interface
Parameters:
- WIDTH, 16, bit width of period, active and the internal counter
- CHANNELS, 4, number of PWM outputs (1..16)

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  pulse; begins generation from IDLE
- stop  input  1  pulse; halts generation, returns to IDLE
- load  input  1  pulse; requests a period/active update while running
- center_mode  input  1  0 = edge-aligned, 1 = center-aligned; sampled only on start
- period  input  WIDTH  period in clocks (edge mode) or half-period (center mode)
- active  input  CHANNELS*WIDTH  per-channel on-count; channel i = active[i*WIDTH +: WIDTH]
- pwm_out  output  CHANNELS  PWM outputs
- running  output  1  high while in RUN
- period_tick  output  1  one-cycle pulse in the last cycle of each full PWM cycle
- load_ack  output  1  one-cycle pulse in the cycle the buffered update is applied

## Operation
- States: IDLE, RUN. Reset forces IDLE, counter 0, direction up, pending flag 0, working/shadow registers 0, all outputs 0.
- IDLE -> RUN on start when period != 0. On the same edge, period, all active values and center_mode are captured into working registers. start with period == 0 is ignored.
- RUN -> IDLE on stop. stop has priority over start and load in the same cycle. reset has priority over everything.
- start while in RUN is ignored.
- Edge mode: counter runs 0..P-1 and wraps to 0. pwm_out[i] = (cnt < A[i]). The full cycle is P clocks.
- Center mode: counter runs up 0..P-1, then down P-1..0, with each end value held for one cycle. The full cycle is 2P clocks. pwm_out[i] = (cnt >= P - A[i]), giving a symmetric pulse of 2*A[i] clocks.
- Saturation: A[i] == 0 keeps the channel low. A[i] >= P keeps it high. No wrap or underflow in P - A[i]; compare with saturation.
- Comparisons are unsigned, WIDTH bits. The counter never exceeds P-1.
- load in RUN captures period and active into shadow registers and sets pending.
  - A second load while pending overwrites the shadow (latest wins).
  - load with period == 0 is ignored.
  - load in IDLE is ignored.
- At the end of a full cycle with pending set, working registers take the shadow values, the counter restarts at 0 (direction up) and pending clears. load_ack pulses in that cycle.
- In IDLE: pwm_out = 0, running = 0, period_tick = 0, load_ack = 0.

## Timing
- Outputs are registered. In the first cycle after the start edge, running = 1 and cnt = 0, and pwm_out reflects cnt = 0.
- Edge mode: pwm_out[i] is high for exactly A[i] cycles starting at the cycle after start, then low for P - A[i] cycles, repeating.
- period_tick is high in the cycle where cnt = P-1 (edge mode), or where cnt = 0 in the down phase (center mode).
- load_ack coincides with period_tick. The new values govern from the next cycle (new cnt = 0).
- stop edge: in the next cycle running = 0 and pwm_out = 0, even mid-pulse.
- reset mid-operation: identical effect to stop, and additionally clears the shadow registers and pending.
- P = 1, edge mode: period_tick is high every cycle; A >= 1 gives a constant-high output.

## Test plan
- Reset, then P=12, A={6,3,9,0}, edge mode, start pulse.
  - pwm_out[0]: 6 high / 6 low.
  - pwm_out[1]: 3 high / 9 low.
  - pwm_out[2]: 9 high / 3 low.
  - pwm_out[3]: constant 0.
  - period_tick every 12 cycles.
- P=12, A[0]=3, center mode: 6 high / 18 low per 24-cycle period, with the high pulse centred around cnt=11. period_tick every 24 cycles.
- While running P=12, A[0]=6, load P=8, A[0]=2 mid-period:
  - the current 12-cycle period completes unchanged;
  - load_ack and period_tick coincide;
  - subsequent periods are 2 high / 6 low.
- Two loads in one period (A[0]=2, then A[0]=5): only A[0]=5 is applied at the boundary, with one load_ack.
- Saturation and degenerate cases:
  - A[0]=12 with P=12 gives constant 1;
  - A[0]=20 with P=12 gives constant 1;
  - start with P=0 leaves running = 0;
  - P=1 gives period_tick every cycle.
- start and stop asserted together in RUN leads to IDLE. reset asserted mid-pulse gives all outputs 0 next cycle; a subsequent start uses freshly captured values, with no stale pending update applied.

Source files
------------

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM driven by one shared period counter.
// Each channel has its own on-count. The block runs edge-aligned or
// center-aligned, and period/active updates are double-buffered so they only
// take effect at a full-cycle boundary.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           pulse; IDLE -> RUN when period != 0 (captures settings)
//   stop            pulse; RUN -> IDLE (priority over start/load)
//   load            pulse; buffers period/active for the next cycle boundary
//   center_mode     0 = edge-aligned, 1 = center-aligned (sampled on start)
//   period          period (edge) or half-period (center), in clocks
//   active          per-channel on-count, channel i = active[i*WIDTH +: WIDTH]
//   pwm_out         registered PWM outputs
//   running         high while in RUN
//   period_tick     pulse in the last cycle of each full PWM cycle
//   load_ack        pulse in the cycle a buffered update is applied
module pwm_multi #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      load,
    input  logic                      center_mode,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] active,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      running,
    output logic                      period_tick,
    output logic                      load_ack
);

    localparam int unsigned AW = CHANNELS * WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state, state_nx;
    logic [WIDTH-1:0]     cnt, cnt_nx;
    logic                 down, down_nx;
    logic                 pending, pending_nx;
    logic                 work_center, work_center_nx;
    logic [WIDTH-1:0]     work_period, work_period_nx;
    logic [AW-1:0]        work_active, work_active_nx;
    logic [WIDTH-1:0]     shadow_period, shadow_period_nx;
    logic [AW-1:0]        shadow_active, shadow_active_nx;
    logic [CHANNELS-1:0]  pwm_nx;
    logic                 tick_nx;
    logic                 ack_nx;
    logic                 at_end;

    // Channel compare. Center mode saturates so that p - a cannot underflow.
    function automatic logic chan_on(input logic [WIDTH-1:0] c,
                                     input logic [WIDTH-1:0] p,
                                     input logic [WIDTH-1:0] a,
                                     input logic             ctr);
        logic on;
        if (!ctr) begin
            on = (c < a);
        end else if (a >= p) begin
            on = 1'b1;
        end else begin
            on = (c >= (p - a));
        end
        return on;
    endfunction

    // Next-state, counter, buffering and output decode.
    // Outputs are registered from the next-cycle values, so they line up
    // with the counter value they describe.
    always_comb begin
        state_nx         = state;
        cnt_nx           = cnt;
        down_nx          = down;
        pending_nx       = pending;
        work_center_nx   = work_center;
        work_period_nx   = work_period;
        work_active_nx   = work_active;
        shadow_period_nx = shadow_period;
        shadow_active_nx = shadow_active;
        pwm_nx           = '0;
        tick_nx          = 1'b0;
        ack_nx           = 1'b0;

        // Last cycle of a full PWM cycle in the current working setup.
        at_end = work_center ? (down && (cnt == '0))
                             : (cnt == (work_period - WIDTH'(1)));

        case (state)
            IDLE: begin
                if (start && (period != '0)) begin
                    state_nx       = RUN;
                    cnt_nx         = '0;
                    down_nx        = 1'b0;
                    work_period_nx = period;
                    work_active_nx = active;
                    work_center_nx = center_mode;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    down_nx  = 1'b0;
                end else begin
                    if (at_end) begin
                        cnt_nx  = '0;
                        down_nx = 1'b0;
                        if (pending) begin
                            work_period_nx = shadow_period;
                            work_active_nx = shadow_active;
                            pending_nx     = 1'b0;
                        end
                    end else if (!work_center) begin
                        cnt_nx = cnt + WIDTH'(1);
                    end else if (!down) begin
                        // Top value is held for a second cycle on the turn.
                        if (cnt == (work_period - WIDTH'(1))) begin
                            down_nx = 1'b1;
                        end else begin
                            cnt_nx = cnt + WIDTH'(1);
                        end
                    end else begin
                        cnt_nx = cnt - WIDTH'(1);
                    end

                    // Shadow capture after the boundary apply: a load in the
                    // boundary cycle is kept for the following boundary.
                    if (load && (period != '0)) begin
                        shadow_period_nx = period;
                        shadow_active_nx = active;
                        pending_nx       = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        if (state_nx == RUN) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                pwm_nx[i] = chan_on(cnt_nx, work_period_nx,
                                    work_active_nx[i*WIDTH +: WIDTH],
                                    work_center_nx);
            end
            tick_nx = work_center_nx ? (down_nx && (cnt_nx == '0))
                                     : (cnt_nx == (work_period_nx - WIDTH'(1)));
            ack_nx  = tick_nx && pending_nx;
        end
    end

    // State, working/shadow registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            down          <= 1'b0;
            pending       <= 1'b0;
            work_center   <= 1'b0;
            work_period   <= '0;
            work_active   <= '0;
            shadow_period <= '0;
            shadow_active <= '0;
            pwm_out       <= '0;
            running       <= 1'b0;
            period_tick   <= 1'b0;
            load_ack      <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            down          <= down_nx;
            pending       <= pending_nx;
            work_center   <= work_center_nx;
            work_period   <= work_period_nx;
            work_active   <= work_active_nx;
            shadow_period <= shadow_period_nx;
            shadow_active <= shadow_active_nx;
            pwm_out       <= pwm_nx;
            running       <= (state_nx == RUN);
            period_tick   <= tick_nx;
            load_ack      <= ack_nx;
        end
    end

endmodule
